// File: rtl/aes_dec_pkg.sv
// -----------------------------------------------------------------------------
// aes_dec_pkg
// Shared definitions for the iterative AES-128 inverse cipher:
//   - FSM state encoding
//   - round count and key-schedule round constants
//   - GF(2^8) helpers (xtime, gmul) plus the InvShiftRows / InvMixColumns
//     state transforms used by the round datapath
// Byte order everywhere: byte 0 of a 128-bit block sits in bits [127:120],
// and state byte n = column n/4, row n%4 (column-major, as in FIPS-197).
// -----------------------------------------------------------------------------
package aes_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } dec_state_e;

    localparam int NR = 10;

    localparam logic [7:0] RCON [0:NR-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant lookup; out-of-range indices return zero.
    function automatic logic [7:0] rcon_f(input logic [3:0] idx);
        logic [7:0] r;
        if (idx < 4'd10) begin
            r = RCON[idx];
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r of the state rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Column-wise multiply by the inverse MixColumns matrix {0e,0b,0d,09}.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_128_dec_sbox.sv
// -----------------------------------------------------------------------------
// AES byte substitution tables (purely combinational).
//   aes_fwd_sbox : forward S-box, used by the key schedule.
//   aes_inv_sbox : inverse S-box, used on the state path.
// Ports (both modules):
//   byte_i [7:0] in   byte to substitute
//   byte_o [7:0] out  substituted byte
// -----------------------------------------------------------------------------
module aes_fwd_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    localparam logic [0:255][7:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = TABLE[byte_i];
endmodule

module aes_inv_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    localparam logic [0:255][7:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign byte_o = TABLE[byte_i];
endmodule

// File: rtl/aes_128_dec.sv
// -----------------------------------------------------------------------------
// aes_128_dec
// Iterative AES-128 inverse cipher. A block (ct + key) is accepted in IDLE;
// the key is expanded forward to K10 (10 cycles), then 10 inverse rounds run
// while the key schedule is unwound one round key per cycle. An optional
// single-entry cache of the last expanded K10 lets a repeated key skip the
// expansion phase.
// Parameters:
//   KEY_CACHE  1 = keep last K10 and skip EXPAND on key match, 0 = always expand
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   ct/key valid
//   in_ready   out  high only in IDLE
//   ct[127:0]  in   ciphertext
//   key[127:0] in   cipher key
//   out_valid  out  pt valid, held until out_ready
//   out_ready  in   consumer accepts pt
//   pt[127:0]  out  plaintext
// -----------------------------------------------------------------------------
module aes_128_dec
    import aes_dec_pkg::*;
#(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    dec_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] s_q, s_d;
    logic [127:0] pt_q, pt_d;
    logic         out_valid_q, out_valid_d;
    logic         cache_valid_q, cache_valid_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_k10_q, cache_k10_d;

    logic         cache_hit_s;
    logic [31:0]  ks_word_s;
    logic [31:0]  rot_word_s;
    logic [31:0]  sub_word_s;
    logic [7:0]   rcon_s;
    logic [31:0]  fw0_s, fw1_s, fw2_s, fw3_s;
    logic [127:0] fwd_next_s;
    logic [127:0] inv_next_s;
    logic [127:0] shifted_s;
    logic [127:0] sub_state_s;
    logic [127:0] ark_s;
    logic [127:0] mixed_s;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign pt        = pt_q;

    assign cache_hit_s = (KEY_CACHE != 0) && cache_valid_q && (key == cache_key_q);

    // Key schedule: the four forward S-boxes are shared. Expansion feeds them
    // w3; unwinding needs w3 of the previous round key, which is w3^w2 here.
    assign ks_word_s  = (state_q == ST_ROUND) ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
    assign rot_word_s = {ks_word_s[23:0], ks_word_s[31:24]};
    assign rcon_s     = rcon_f(cnt_q);

    for (genvar g = 0; g < 4; g++) begin : g_fwd_sbox
        aes_fwd_sbox u_fwd_sbox (
            .byte_i (rot_word_s[31-8*g -: 8]),
            .byte_o (sub_word_s[31-8*g -: 8])
        );
    end

    assign fw0_s      = rk_q[127:96] ^ sub_word_s ^ {rcon_s, 24'h000000};
    assign fw1_s      = rk_q[95:64] ^ fw0_s;
    assign fw2_s      = rk_q[63:32] ^ fw1_s;
    assign fw3_s      = rk_q[31:0]  ^ fw2_s;
    assign fwd_next_s = {fw0_s, fw1_s, fw2_s, fw3_s};

    assign inv_next_s = {rk_q[127:96] ^ sub_word_s ^ {rcon_s, 24'h000000},
                         rk_q[95:64]  ^ rk_q[127:96],
                         rk_q[63:32]  ^ rk_q[95:64],
                         rk_q[31:0]   ^ rk_q[63:32]};

    // State path: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    assign shifted_s = inv_shift_rows(s_q);

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (
            .byte_i (shifted_s[127-8*g -: 8]),
            .byte_o (sub_state_s[127-8*g -: 8])
        );
    end

    assign ark_s   = sub_state_s ^ inv_next_s;
    assign mixed_s = inv_mix_columns(ark_s);

    // Next-state and datapath control for the IDLE/EXPAND/ROUND/DONE sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ct_d          = ct_q;
        key_d         = key_q;
        rk_d          = rk_q;
        s_d           = s_q;
        pt_d          = pt_q;
        out_valid_d   = out_valid_q;
        cache_valid_d = cache_valid_q;
        cache_key_d   = cache_key_q;
        cache_k10_d   = cache_k10_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ct_d  = ct;
                    key_d = key;
                    if (cache_hit_s) begin
                        s_d     = ct ^ cache_k10_q;
                        rk_d    = cache_k10_q;
                        cnt_d   = 4'(NR - 1);
                        state_d = ST_ROUND;
                    end else begin
                        rk_d    = key;
                        cnt_d   = 4'd0;
                        state_d = ST_EXPAND;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXPAND: begin
                rk_d = fwd_next_s;
                if (cnt_q == 4'(NR - 1)) begin
                    // Last expansion step also performs the initial AddRoundKey.
                    s_d     = ct_q ^ fwd_next_s;
                    cnt_d   = 4'(NR - 1);
                    state_d = ST_ROUND;
                    if (KEY_CACHE != 0) begin
                        cache_key_d   = key_q;
                        cache_k10_d   = fwd_next_s;
                        cache_valid_d = 1'b1;
                    end else begin
                        cache_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_ROUND: begin
                rk_d = inv_next_s;
                if (cnt_q == 4'd0) begin
                    // Final round has no InvMixColumns.
                    pt_d        = ark_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    s_d   = mixed_s;
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            ct_q          <= 128'h0;
            key_q         <= 128'h0;
            rk_q          <= 128'h0;
            s_q           <= 128'h0;
            pt_q          <= 128'h0;
            out_valid_q   <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_key_q   <= 128'h0;
            cache_k10_q   <= 128'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ct_q          <= ct_d;
            key_q         <= key_d;
            rk_q          <= rk_d;
            s_q           <= s_d;
            pt_q          <= pt_d;
            out_valid_q   <= out_valid_d;
            cache_valid_q <= cache_valid_d;
            cache_key_q   <= cache_key_d;
            cache_k10_q   <= cache_k10_d;
        end
    end

endmodule

// File: doc/aes_128_dec.md
Name: aes_128_dec

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 decryption); it is the decrypt counterpart of the pipelined aes_128 encryption core.
- Accepts one 128-bit ciphertext plus cipher key over a valid/ready handshake.
- Expands the key forward to the round-10 key, then runs 10 inverse rounds while unwinding the key schedule on the fly.
- Optional single-entry round-10 key cache skips expansion when the key repeats.

Parameters:
- KEY_CACHE, 1, 1 = keep last expanded round-10 key and skip EXPAND on a key match; 0 = always expand.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  ct/key valid.
- in_ready  out  1  block can accept; high only in IDLE.
- ct  in  128  ciphertext, byte 0 = bits [127:120].
- key  in  128  cipher key, same byte order.
- out_valid  out  1  pt valid.
- out_ready  in  1  consumer accepts pt.
- pt  out  128  plaintext.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, out_valid=0, pt=0, cache_valid=0, counters=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation abandons the block; no output is produced.
- FSM states: IDLE, EXPAND, ROUND, DONE.
- IDLE: on in_valid&in_ready, latch ct and key.
  - Cache hit (KEY_CACHE=1, cache_valid, key==cache_key): s<=ct^cache_k10, rk<=cache_k10, r<=9, go ROUND.
  - Otherwise: rk<=key, i<=0, go EXPAND.
- EXPAND: 10 edges, i=0..9.
  - Each edge: rk<=fwd_next(rk, RCON[i]), with fwd_next as FIPS-197 (RotWord, SubWord, rcon on byte 0).
  - Edge i=9 additionally: s<=ct^fwd_next(rk,RCON[9]); rk<=that K10; if KEY_CACHE, cache_key<=latched key, cache_k10<=K10, cache_valid<=1; r<=9; go ROUND.
- ROUND: 10 edges, r=9 down to 0.
  - kp = inv_next(rk, RCON[r]) is K_r, computed as:
    - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
    - w0'=w0^SubWord(RotWord(w3'))^{RCON[r],24'h0}
  - r>=1: s<=InvMixColumns(InvSubBytes(InvShiftRows(s))^kp).
  - r=0: pt<=InvSubBytes(InvShiftRows(s))^kp (kp must equal K0 = key), out_valid<=1, go DONE.
  - rk<=kp; r<=r-1.
- DONE: pt and out_valid held stable while out_ready=0. On out_ready=1: out_valid<=0, go IDLE.
- in_ready is combinational (state==IDLE); no overlap of output and input. Throughput is one block per 22 cycles on a miss, 12 on a hit, with out_ready tied high.
- Latency, counted from the accept edge to the first cycle with out_valid=1: 21 cycles on a miss, 11 on a hit.
- in_valid/ct/key are ignored outside IDLE. in_valid may drop without being accepted.
- Cache replacement: the latest expanded key always overwrites the cache. A hit never updates the cache.
- GF(2^8) arithmetic: xtime reduction poly 0x11B. InvMixColumns coefficients are 0e, 0b, 0d, 09.

Decomposition:
- Package aes_dec_pkg holds:
  - state enum
  - RCON[0:9] = 01,02,04,08,10,20,40,80,1b,36
  - NR=10
  - xtime/gmul functions
- Natural sub-module: aes_inv_sbox, a combinational 256-entry byte table.
  - 16 instances on the state path.
- Forward S-box for the key schedule: combinational table aes_fwd_sbox, 4 instances shared by fwd_next and inv_next via a state mux.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid at cycle +21; internal K10 = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734; K10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Cache hit: repeat the App. B key with the same ct -> same pt at +11. With KEY_CACHE=0 the same stimulus completes at +21.
- Back-pressure: out_ready=0 for 7 cycles after out_valid -> pt constant, in_ready=0 throughout; then out_ready=1 -> in_ready=1 the next cycle.
- Reset mid-ROUND (rst_n=0 for 1 cycle at accept+15) -> out_valid never asserts for that block. The next App. B block takes 21 cycles, since the cache was cleared.
- Alternating keys C.1 / App. B / C.1 -> each is a miss (21 cycles) and pts are correct; in_valid pulses while busy are ignored.
